// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALU opcode constants, datapath width and scheduler states.
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] SLA  = 3'b000;
  localparam logic [2:0] SRA  = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] MUL  = 3'b100;
  localparam logic [2:0] ANDD = 3'b101;
  localparam logic [2:0] ORD  = 3'b110;
  localparam logic [2:0] NOTD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module  : alu
// Brief   : Combinational ALU; status d = {carry/borrow, negative, zero}.
// Revision: 1.0
// ============================================================================
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] c,
  output logic [2:0]       d
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = '0;
    c     = '0;
    case (opcode)
      SLA:  c = a << b[SHW-1:0];
      SRA:  c = $signed(a) >>> b[SHW-1:0];
      ADD:  begin
        w_sum = {1'b0, a} + {1'b0, b};
        c     = w_sum[WIDTH-1:0];
      end
      SUB:  begin
        w_sum = {1'b0, a} - {1'b0, b};
        c     = w_sum[WIDTH-1:0];
      end
      MUL:  c = a * b;
      ANDD: c = a & b;
      ORD:  c = a | b;
      NOTD: c = ~a;
    endcase
  end

  assign d = {w_sum[WIDTH], c[WIDTH-1], (c == '0)};

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// Module  : alu_sched
// Brief   : Round-robin two-requester sequencer around one shared alu.
//           Define ALU_SCHED_MULWAIT_EN to hold mul operands MUL_WAIT cycles.
// Revision: 1.0
// ============================================================================
module alu_sched #(
  parameter int WIDTH    = 32,
  parameter int MUL_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic [2:0]       rsp_d
);
  import alu_pkg::*;

  if (MUL_WAIT < 1 || MUL_WAIT > 15) begin : g_mul_wait_range
    $error("alu_sched: MUL_WAIT must be within 1..15");
  end

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
  logic [2:0]       rsp_d_q, rsp_d_d;
`ifdef ALU_SCHED_MULWAIT_EN
  logic [3:0]       cnt_q, cnt_d;
`endif

  logic             w_gnt0, w_gnt1, w_capture;
  logic [WIDTH-1:0] w_alu_c;
  logic [2:0]       w_alu_d;

  // last_grant_q=1 means req1 was served last, so req0 wins a tie.
  assign w_gnt0 = req0_valid & (~req1_valid |  last_grant_q);
  assign w_gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .opcode (op_q),
    .c      (w_alu_c),
    .d      (w_alu_d)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_c_d      = rsp_c_q;
    rsp_d_d      = rsp_d_q;
`ifdef ALU_SCHED_MULWAIT_EN
    cnt_d        = cnt_q;
`endif
    w_capture    = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (w_gnt0 || w_gnt1)) begin
          req0_ready   = w_gnt0;
          req1_ready   = w_gnt1;
          a_d          = w_gnt1 ? req1_a  : req0_a;
          b_d          = w_gnt1 ? req1_b  : req0_b;
          op_d         = w_gnt1 ? req1_op : req0_op;
          id_d         = w_gnt1;
          last_grant_d = w_gnt1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        w_capture = 1'b1;
`ifdef ALU_SCHED_MULWAIT_EN
        if (op_q == MUL) begin
          w_capture = 1'b0;
          cnt_d     = 4'(MUL_WAIT);
          state_d   = WAIT;
        end
`endif
      end
`ifdef ALU_SCHED_MULWAIT_EN
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) w_capture = 1'b1;
      end
`endif
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (w_capture) begin
      rsp_id_d = id_q;
      rsp_c_d  = w_alu_c;
      rsp_d_d  = w_alu_d;
      state_d  = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_c_q      <= '0;
      rsp_d_q      <= '0;
`ifdef ALU_SCHED_MULWAIT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_c_q      <= rsp_c_d;
      rsp_d_q      <= rsp_d_d;
`ifdef ALU_SCHED_MULWAIT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_d     = rsp_d_q;

endmodule
`default_nettype wire
